uart_echo_buffer: RTL and testbench

Parametrised successor to the direct rx-to-tx UART loopback. It sits between uart_rx and uart_tx and buffers received words in a FIFO, so back-to-back receive traffic is never lost while the transmitter is busy. It also provides selectable echo modes, a captured-data display register, and sticky status flags. It is clocked on the same system clock as the UART cores.

---
 rtl/uart_echo_buffer_pkg.sv | 30 +++
 rtl/uart_word_fifo.sv | 60 ++++++
 rtl/uart_echo_buffer.sv | 144 ++++++++++++++
 tb/tb_uart_echo_buffer.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_echo_buffer_pkg.sv
// Shared encodings for the UART echo buffer: echo modes, transmit FSM states
// and the ASCII letter ranges used by the case-swap transform.
package uart_echo_buffer_pkg;

  typedef enum logic [1:0] {
    MODE_ECHO      = 2'b00,
    MODE_CASE_SWAP = 2'b01,
    MODE_HOLD      = 2'b10,
    MODE_DROP      = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'b00,
    TX_ISSUE = 2'b01,
    TX_ARM   = 2'b10,
    TX_DRAIN = 2'b11
  } tx_state_e;

  localparam logic [7:0] ASCII_UPPER_FIRST = 8'h41;
  localparam logic [7:0] ASCII_UPPER_LAST  = 8'h5A;
  localparam logic [7:0] ASCII_LOWER_FIRST = 8'h61;
  localparam logic [7:0] ASCII_LOWER_LAST  = 8'h7A;
  localparam int         CASE_BIT          = 5;

  function automatic logic is_ascii_letter(input logic [7:0] word);
    return ((word >= ASCII_UPPER_FIRST) && (word <= ASCII_UPPER_LAST)) ||
           ((word >= ASCII_LOWER_FIRST) && (word <= ASCII_LOWER_LAST));
  endfunction

endpackage

// File: rtl/uart_word_fifo.sv
// Show-ahead synchronous FIFO for UART words; full/empty come from the level
// counter so the pointers can simply wrap modulo the power-of-two depth.
module uart_word_fifo #(
  parameter int PAYLOAD_BITS = 8,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          push,
  input  logic                          pop,
  input  logic [PAYLOAD_BITS-1:0]       din,
  output logic [PAYLOAD_BITS-1:0]       dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic                    do_push;
  logic                    do_pop;

  assign full    = (level == LVL_W'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_echo_buffer.sv
// Buffered UART echo: rx words are queued (optionally case-swapped) and
// replayed to uart_tx one at a time, with hold/flush control and sticky status.
module uart_echo_buffer #(
  parameter int                      PAYLOAD_BITS = 8,
  parameter int                      FIFO_DEPTH   = 16,
  parameter logic [PAYLOAD_BITS-1:0] LED_RESET    = PAYLOAD_BITS'(8'hF0)
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [1:0]                  mode,
  input  logic                        flush,
  input  logic                        clr_status,
  input  logic [PAYLOAD_BITS-1:0]     uart_rx_data,
  input  logic                        uart_rx_valid,
  input  logic                        uart_rx_break,
  input  logic                        uart_tx_busy,
  output logic [PAYLOAD_BITS-1:0]     uart_tx_data,
  output logic                        uart_tx_en,
  output logic [PAYLOAD_BITS-1:0]     led,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic                        break_seen
);

  import uart_echo_buffer_pkg::*;

  tx_state_e               state;
  tx_state_e               state_next;
  logic [PAYLOAD_BITS-1:0] push_word;
  logic [PAYLOAD_BITS-1:0] fifo_head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_pop;
  logic                    push_req;
  logic                    tx_load;
  logic                    release_latch;
  logic                    release_ok;
  logic                    break_rise;

  assign push_req   = uart_rx_valid && (mode != MODE_DROP);
  assign break_rise = uart_rx_break && !break_seen;
  assign release_ok = (mode != MODE_HOLD) || release_latch;

  always_comb begin
    push_word = uart_rx_data;
    if (PAYLOAD_BITS == 8 && mode == MODE_CASE_SWAP && is_ascii_letter(uart_rx_data[7:0])) begin
      push_word[CASE_BIT] = ~uart_rx_data[CASE_BIT];
    end
  end

  uart_word_fifo #(
    .PAYLOAD_BITS (PAYLOAD_BITS),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push_req),
    .pop    (fifo_pop),
    .din    (push_word),
    .dout   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  // Sticky status: in a cycle with both a set event and clr_status, the set wins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led        <= LED_RESET;
      overflow   <= 1'b0;
      break_seen <= 1'b0;
    end else begin
      if (push_req) begin
        led <= uart_rx_data;
      end else if (clr_status) begin
        led <= LED_RESET;
      end
      if (push_req && fifo_full && !fifo_pop) begin
        overflow <= 1'b1;
      end else if (clr_status) begin
        overflow <= 1'b0;
      end
      if (uart_rx_break) begin
        break_seen <= 1'b1;
      end else if (clr_status) begin
        break_seen <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      release_latch <= 1'b0;
    end else if (flush || break_rise) begin
      release_latch <= 1'b1;
    end else if (fifo_empty) begin
      release_latch <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= TX_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ARM ignores busy for one cycle because uart_tx raises it a cycle after the strobe.
  always_comb begin
    state_next = state;
    unique case (state)
      TX_IDLE:  if (!fifo_empty && !uart_tx_busy && release_ok) state_next = TX_ISSUE;
      TX_ISSUE: state_next = TX_ARM;
      TX_ARM:   state_next = TX_DRAIN;
      TX_DRAIN: if (!uart_tx_busy) state_next = TX_IDLE;
      default:  state_next = TX_IDLE;
    endcase
  end

  always_comb begin
    uart_tx_en = 1'b0;
    fifo_pop   = 1'b0;
    tx_load    = 1'b0;
    unique case (state)
      TX_IDLE:  tx_load = (state_next == TX_ISSUE);
      TX_ISSUE: begin
        uart_tx_en = 1'b1;
        fifo_pop   = 1'b1;
      end
      default:  tx_load = 1'b0;
    endcase
  end

  // The head is captured on entry to ISSUE and held until the next ISSUE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      uart_tx_data <= '0;
    end else if (tx_load) begin
      uart_tx_data <= fifo_head;
    end
  end

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Self-checking bench for uart_echo_buffer: a queue-based reference model plus a
// simple uart_tx stand-in that stays busy for 10 cycles after every strobe.
module tb_uart_echo_buffer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       resetn;
  logic [1:0] mode;
  logic       flush;
  logic       clr_status;
  logic [7:0] uart_rx_data;
  logic       uart_rx_valid;
  logic       uart_rx_break;
  logic       uart_tx_busy;
  logic [7:0] uart_tx_data;
  logic       uart_tx_en;
  logic [7:0] led;
  logic [2:0] fifo_level;
  logic       overflow;
  logic       break_seen;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_q [$];
  logic [7:0] exp_tx [$];
  logic [7:0] act_tx [$];
  logic       exp_ovf;
  logic       exp_brk;
  logic [7:0] exp_led;
  int         busy_cnt;

  uart_echo_buffer #(
    .PAYLOAD_BITS (8),
    .FIFO_DEPTH   (DEPTH),
    .LED_RESET    (8'hF0)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .mode          (mode),
    .flush         (flush),
    .clr_status    (clr_status),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_break (uart_rx_break),
    .uart_tx_busy  (uart_tx_busy),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_en    (uart_tx_en),
    .led           (led),
    .fifo_level    (fifo_level),
    .overflow      (overflow),
    .break_seen    (break_seen)
  );

  always #5 clk = ~clk;

  assign uart_tx_busy = (busy_cnt != 0);

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_cnt <= 0;
    end else if (uart_tx_en) begin
      busy_cnt <= 10;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  function automatic logic [7:0] swap_case(input logic [7:0] w);
    if ((w >= "A" && w <= "Z") || (w >= "a" && w <= "z")) return w ^ 8'h20;
    return w;
  endfunction

  // Reference model: the transmitter's strobe is the consumer; everything the
  // design should have queued and emitted is derived from rx traffic alone.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      model_q.delete();
      exp_ovf <= 1'b0;
      exp_brk <= 1'b0;
      exp_led <= 8'hF0;
    end else begin
      if (uart_tx_en) begin
        act_tx.push_back(uart_tx_data);
        if (model_q.size() > 0) exp_tx.push_back(model_q.pop_front());
        else exp_tx.push_back(8'hxx);
      end
      if (uart_rx_valid && mode != 2'b11) begin
        exp_led <= uart_rx_data;
        if (model_q.size() < DEPTH)
          model_q.push_back(mode == 2'b01 ? swap_case(uart_rx_data) : uart_rx_data);
        else
          exp_ovf <= 1'b1;
      end else if (clr_status) begin
        exp_led <= 8'hF0;
      end
      if (uart_rx_valid && mode != 2'b11 && model_q.size() >= DEPTH && !uart_tx_en) begin
        exp_ovf <= 1'b1;
      end else if (clr_status && !(uart_rx_valid && mode != 2'b11 && model_q.size() >= DEPTH)) begin
        exp_ovf <= 1'b0;
      end
      if (uart_rx_break) exp_brk <= 1'b1;
      else if (clr_status) exp_brk <= 1'b0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] w);
    uart_rx_data  = w;
    uart_rx_valid = 1'b1;
    tick();
    uart_rx_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
  endtask

  task automatic wait_tx(input int target, input int budget, output bit ok);
    int n = 0;
    while (act_tx.size() < target && n < budget) begin
      tick();
      n++;
    end
    ok = (act_tx.size() >= target);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick(3);
    checks++; if (uart_tx_en !== 1'b0) begin errors++; $display("FAIL reset_tx_en: got %b want 0", uart_tx_en); end
    checks++; if (uart_tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", uart_tx_data); end
    checks++; if (led !== 8'hF0) begin errors++; $display("FAIL reset_led: got %h want f0", led); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (break_seen !== 1'b0) begin errors++; $display("FAIL reset_break_seen: got %b want 0", break_seen); end
    resetn = 1'b1;
    tick(2);
  endtask

  task automatic test_echo_latency();
    mode = 2'b00;
    uart_rx_data  = 8'h55;
    uart_rx_valid = 1'b1;
    tick();
    uart_rx_valid = 1'b0;
    checks++; if (uart_tx_en !== 1'b0) begin errors++; $display("FAIL echo_early_en: got %b want 0", uart_tx_en); end
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL echo_level: got %0d want 1", fifo_level); end
    tick();
    checks++; if (uart_tx_en !== 1'b1) begin errors++; $display("FAIL echo_en: got %b want 1", uart_tx_en); end
    checks++; if (uart_tx_data !== 8'h55) begin errors++; $display("FAIL echo_data: got %h want 55", uart_tx_data); end
    checks++; if (led !== 8'h55) begin errors++; $display("FAIL echo_led: got %h want 55", led); end
    tick();
    checks++; if (uart_tx_en !== 1'b0) begin errors++; $display("FAIL echo_single_strobe: got %b want 0", uart_tx_en); end
    tick(16);
  endtask

  task automatic test_burst();
    int base = act_tx.size();
    int max_level = 0;
    bit ok;
    for (int i = 1; i <= 5; i++) begin
      send(8'(i));
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
    end
    wait_tx(base + 5, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL burst_timeout: got %0d words want 5", act_tx.size() - base); end
    for (int i = 0; i < 5 && ok; i++) begin
      checks++;
      if (act_tx[base + i] !== 8'(i + 1)) begin
        errors++; $display("FAIL burst_order[%0d]: got %h want %h", i, act_tx[base + i], 8'(i + 1));
      end
    end
    checks++; if (max_level < 4 || max_level > 5) begin errors++; $display("FAIL burst_max_level: got %0d want 4 or 5", max_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL burst_overflow: got %b want 0", overflow); end
    tick(16);
  endtask

  task automatic test_hold_overflow();
    int base = act_tx.size();
    bit ok;
    mode = 2'b10;
    tick();
    for (int i = 0; i < 6; i++) send(8'hA0 + 8'(i));
    tick(20);
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL hold_level: got %0d want 4", fifo_level); end
    checks++; if (overflow !== 1'b1 || exp_ovf !== 1'b1) begin errors++; $display("FAIL hold_overflow: got %b want 1", overflow); end
    checks++; if (act_tx.size() != base) begin errors++; $display("FAIL hold_no_tx: got %0d words want 0", act_tx.size() - base); end
    checks++; if (led !== 8'hA5) begin errors++; $display("FAIL hold_led: got %h want a5", led); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_tx(base + 4, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL hold_flush_timeout: got %0d words want 4", act_tx.size() - base); end
    for (int i = 0; i < 4 && ok; i++) begin
      checks++;
      if (act_tx[base + i] !== 8'hA0 + 8'(i)) begin
        errors++; $display("FAIL hold_flush_order[%0d]: got %h want %h", i, act_tx[base + i], 8'hA0 + 8'(i));
      end
    end
    tick(20);
    send(8'hB0);
    tick(30);
    checks++; if (act_tx.size() != base + 4) begin errors++; $display("FAIL hold_latch_cleared: got %0d words want 4", act_tx.size() - base); end
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL hold_latched_level: got %0d want 1", fifo_level); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_tx(base + 5, 100, ok);
    checks++; if (!ok || act_tx[base + 4] !== 8'hB0) begin errors++; $display("FAIL hold_second_flush: got %0d words want 5", act_tx.size() - base); end
    tick(16);
    pulse_clr();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_overflow: got %b want 0", overflow); end
    checks++; if (led !== 8'hF0) begin errors++; $display("FAIL clr_led: got %h want f0", led); end
  endtask

  task automatic test_case_swap();
    int base = act_tx.size();
    logic [7:0] want [3] = '{8'h41, 8'h7A, 8'h31};
    bit ok;
    mode = 2'b01;
    tick();
    send(8'h61);
    tick(20);
    send(8'h5A);
    send(8'h31);
    wait_tx(base + 3, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL swap_timeout: got %0d words want 3", act_tx.size() - base); end
    for (int i = 0; i < 3 && ok; i++) begin
      checks++;
      if (act_tx[base + i] !== want[i]) begin
        errors++; $display("FAIL swap_word[%0d]: got %h want %h", i, act_tx[base + i], want[i]);
      end
    end
    tick(16);
  endtask

  task automatic test_break_release();
    int base = act_tx.size();
    bit ok;
    mode = 2'b10;
    tick();
    send(8'hC1);
    send(8'hC2);
    send(8'hC3);
    tick(20);
    checks++; if (act_tx.size() != base || fifo_level !== 3'd3) begin errors++; $display("FAIL break_held: got %0d words level %0d want 0 words level 3", act_tx.size() - base, fifo_level); end
    uart_rx_break = 1'b1;
    tick();
    uart_rx_break = 1'b0;
    checks++; if (break_seen !== 1'b1 || exp_brk !== 1'b1) begin errors++; $display("FAIL break_seen: got %b want 1", break_seen); end
    wait_tx(base + 3, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL break_release_timeout: got %0d words want 3", act_tx.size() - base); end
    for (int i = 0; i < 3 && ok; i++) begin
      checks++;
      if (act_tx[base + i] !== 8'hC1 + 8'(i)) begin
        errors++; $display("FAIL break_order[%0d]: got %h want %h", i, act_tx[base + i], 8'hC1 + 8'(i));
      end
    end
    tick(16);
    pulse_clr();
    checks++; if (break_seen !== 1'b0) begin errors++; $display("FAIL break_clear: got %b want 0", break_seen); end
  endtask

  task automatic test_drop();
    int base = act_tx.size();
    mode = 2'b11;
    tick();
    send(8'hAA);
    tick(20);
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL drop_level: got %0d want 0", fifo_level); end
    checks++; if (led !== 8'hF0) begin errors++; $display("FAIL drop_led: got %h want f0", led); end
    checks++; if (act_tx.size() != base) begin errors++; $display("FAIL drop_no_tx: got %0d words want 0", act_tx.size() - base); end
  endtask

  task automatic test_random_traffic();
    int base = act_tx.size();
    int n = 0;
    for (int i = 0; i < 40; i++) begin
      mode = 2'($urandom_range(0, 1));
      send(8'($urandom));
      tick($urandom_range(0, 6));
    end
    while ((model_q.size() != 0 || fifo_level !== 3'd0 || uart_tx_busy) && n < 3000) begin
      tick();
      n++;
    end
    checks++; if (n >= 3000) begin errors++; $display("FAIL random_drain_timeout: got level %0d want 0", fifo_level); end
    checks++; if (act_tx.size() != exp_tx.size() || act_tx.size() == base) begin errors++; $display("FAIL random_count: got %0d want %0d", act_tx.size(), exp_tx.size()); end
    for (int i = base; i < act_tx.size() && i < exp_tx.size(); i++) begin
      checks++;
      if (act_tx[i] !== exp_tx[i]) begin
        errors++; $display("FAIL random_word[%0d]: got %h want %h", i - base, act_tx[i], exp_tx[i]);
      end
    end
    checks++; if (overflow !== exp_ovf) begin errors++; $display("FAIL random_overflow: got %b want %b", overflow, exp_ovf); end
    checks++; if (led !== exp_led) begin errors++; $display("FAIL random_led: got %h want %h", led, exp_led); end
    checks++; if (fifo_level !== 3'(model_q.size())) begin errors++; $display("FAIL random_level: got %0d want %0d", fifo_level, model_q.size()); end
    pulse_clr();
    tick(4);
  endtask

  task automatic test_reset_mid_drain();
    int base;
    bit ok;
    mode = 2'b00;
    base = act_tx.size();
    send(8'h77);
    wait_tx(base + 1, 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL drain_setup_timeout: got %0d words want 1", act_tx.size() - base); end
    tick(3);
    #2 resetn = 1'b0;
    #1;
    checks++; if (uart_tx_data !== 8'h00) begin errors++; $display("FAIL async_tx_data: got %h want 00", uart_tx_data); end
    checks++; if (led !== 8'hF0) begin errors++; $display("FAIL async_led: got %h want f0", led); end
    checks++; if (uart_tx_en !== 1'b0 || fifo_level !== 3'd0) begin errors++; $display("FAIL async_en_level: got en %b level %0d want 0 0", uart_tx_en, fifo_level); end
    checks++; if (overflow !== 1'b0 || break_seen !== 1'b0) begin errors++; $display("FAIL async_flags: got %b %b want 0 0", overflow, break_seen); end
    tick(2);
    resetn = 1'b1;
    tick(20);
    checks++; if (act_tx.size() != base + 1) begin errors++; $display("FAIL reset_stale_tx: got %0d words want 1", act_tx.size() - base); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_post_level: got %0d want 0", fifo_level); end
  endtask

  initial begin
    resetn        = 1'b0;
    mode          = 2'b00;
    flush         = 1'b0;
    clr_status    = 1'b0;
    uart_rx_data  = 8'h00;
    uart_rx_valid = 1'b0;
    uart_rx_break = 1'b0;
    test_reset();
    test_echo_latency();
    test_burst();
    test_hold_overflow();
    test_case_swap();
    test_break_release();
    test_drop();
    test_random_traffic();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
